// File: rtl/pic_int_sequencer.sv
// pic_int_sequencer
// -----------------
// Interrupt acknowledge sequencer for an 8-input PIC. Requests are latched
// into IRR, filtered by IMR and resolved against ISR with fully nested
// priority. A pending request raises int_o. The two-pulse INTA handshake
// then sets ISR, clears IRR and emits the vector. EOI commands clear ISR
// bits and can optionally rotate the priority order.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   ir_in[7:0]    raw interrupt request lines
//   edge_mode     1 = rising-edge triggered, 0 = level triggered
//   imr[7:0]      mask, a 1 blocks that IR
//   rotate_en     rotate priority on EOI (and on auto-EOI)
//   inta_i        one-cycle pulse per INTA bus cycle
//   eoi_i         one-cycle EOI command strobe
//   eoi_specific  1 = specific EOI at eoi_level, 0 = non-specific
//   eoi_level     IR index for a specific EOI
//   aeoi_i        auto-EOI enable (present only with AUTO_EOI_EN)
//   int_o         registered interrupt request to the CPU
//   vector_o      {VECTOR_BASE, idx}, held until the next vector
//   vector_valid  one-cycle strobe on the second INTA
//   irr_o/isr_o   current IRR / ISR
//
// Build option: define AUTO_EOI_EN to add aeoi_i. With it set, the ISR bit
// of the acknowledged index is cleared on the second INTA.

module pic_int_sequencer #(
  parameter int         NUM_IRQ     = 8,
  parameter logic [4:0] VECTOR_BASE = 5'b00001
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] ir_in,
  input  logic               edge_mode,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic               rotate_en,
  input  logic               inta_i,
  input  logic               eoi_i,
  input  logic               eoi_specific,
  input  logic [2:0]         eoi_level,
`ifdef AUTO_EOI_EN
  input  logic               aeoi_i,
`endif
  output logic               int_o,
  output logic [7:0]         vector_o,
  output logic               vector_valid,
  output logic [NUM_IRQ-1:0] irr_o,
  output logic [NUM_IRQ-1:0] isr_o
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WAIT2 = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] ir_prev_q, ir_prev_d;
  logic [2:0]         lp_q, lp_d;
  logic [2:0]         idx_q, idx_d;
  logic               int_q, int_d;
  logic [7:0]         vector_q, vector_d;
  logic               vld_q, vld_d;

  logic [NUM_IRQ-1:0] ir_set;
  logic [NUM_IRQ-1:0] eoi_clr;
  logic [3:0]         req_rank;
  logic [3:0]         isr_rank;
  logic [2:0]         pend_idx;
  logic [2:0]         isr_idx;
  logic               pending;

  // Rank of the highest-priority set bit of v, where rank 0 is IR (lp+1)
  // and rank 7 is IR lp. Returns 8 when v is empty.
  function automatic logic [3:0] prio_rank(input logic [7:0] v,
                                           input logic [2:0] lp);
    logic [3:0] r;
    r = 4'd8;
    // Walk from lowest to highest priority so the best hit is kept last.
    for (int k = 7; k >= 0; k--) begin
      if (v[3'(lp + 3'(k + 1))]) r = 4'(k);
    end
    return r;
  endfunction

  always_comb begin
    req_rank = prio_rank(irr_q & ~imr, lp_q);
    isr_rank = prio_rank(isr_q, lp_q);
    pend_idx = lp_q + 3'd1 + req_rank[2:0];
    isr_idx  = lp_q + 3'd1 + isr_rank[2:0];
    // Empty ISR ranks as 8, so any unmasked request beats it; an empty
    // request set (also 8) never does.
    pending  = (req_rank < isr_rank);
    ir_set   = edge_mode ? (ir_in & ~ir_prev_q) : ir_in;
  end

  always_comb begin
    state_d   = state_q;
    irr_d     = irr_q | ir_set;
    isr_d     = isr_q;
    ir_prev_d = ir_in;
    lp_d      = lp_q;
    idx_d     = idx_q;
    vector_d  = vector_q;
    vld_d     = 1'b0;
    int_d     = pending && (state_q == S_IDLE);
    eoi_clr   = '0;

    // EOI acts on the pre-ACK ISR; an ACK1 set on the same bit below wins.
    if (eoi_i) begin
      if (eoi_specific) begin
        eoi_clr[eoi_level] = 1'b1;
        if (rotate_en) lp_d = eoi_level;
      end else if (isr_rank != 4'd8) begin
        eoi_clr[isr_idx] = 1'b1;
        if (rotate_en) lp_d = isr_idx;
      end
    end
    isr_d = isr_q & ~eoi_clr;

    case (state_q)
      S_IDLE: begin
        if (inta_i) begin
          if (pending) begin
            idx_d           = pend_idx;
            isr_d[pend_idx] = 1'b1;
            // Clearing after the set merge makes a coincident new edge lose.
            irr_d[pend_idx] = 1'b0;
          end else begin
            idx_d = 3'd7;
          end
          state_d = S_WAIT2;
        end
      end
      S_WAIT2: begin
        if (inta_i) begin
          vector_d = {VECTOR_BASE, idx_q};
          vld_d    = 1'b1;
          state_d  = S_IDLE;
`ifdef AUTO_EOI_EN
          if (aeoi_i) begin
            isr_d[idx_q] = 1'b0;
            if (rotate_en) lp_d = idx_q;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      irr_q     <= '0;
      isr_q     <= '0;
      ir_prev_q <= '0;
      lp_q      <= 3'd7;
      idx_q     <= 3'd0;
      int_q     <= 1'b0;
      vector_q  <= 8'h00;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      ir_prev_q <= ir_prev_d;
      lp_q      <= lp_d;
      idx_q     <= idx_d;
      int_q     <= int_d;
      vector_q  <= vector_d;
      vld_q     <= vld_d;
    end
  end

  assign int_o        = int_q;
  assign vector_o     = vector_q;
  assign vector_valid = vld_q;
  assign irr_o        = irr_q;
  assign isr_o        = isr_q;

endmodule
